// File: rtl/io_seq_pkg.sv
// io_seq_pkg -- shared definitions for the io_seq_monitor slice.
//   state_e        : monitor FSM states
//   exp_value()    : expected pad pattern for a given step index
//   *_DEF          : default parameter values for io_seq_monitor
//   IO_W/STEP_W/CNT_W : bus widths of the monitored pads and status outputs
package io_seq_pkg;

  localparam int unsigned NUM_STEPS_DEF      = 12;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 25000;
  localparam int unsigned STABLE_CYCLES_DEF  = 2;

  localparam int unsigned IO_W   = 8;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned CNT_W  = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_STEP = 2'd1,
    PASS      = 2'd2,
    FAIL      = 2'd3
  } state_e;

  // Expected pattern table: 01..0A, FF, 00.
  function automatic logic [IO_W-1:0] exp_value(input logic [STEP_W-1:0] idx);
    logic [IO_W-1:0] v;
    case (idx)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h03;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h05;
      4'd5:    v = 8'h06;
      4'd6:    v = 8'h07;
      4'd7:    v = 8'h08;
      4'd8:    v = 8'h09;
      4'd9:    v = 8'h0A;
      4'd10:   v = 8'hFF;
      4'd11:   v = 8'h00;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/io_seq_monitor_sync.sv
// io_sync2 -- two-flop synchronizer for an asynchronous bus.
//   clk_i : sampling clock
//   rst_i : asynchronous active-high reset, clears both flop stages
//   d_i   : asynchronous input bus
//   q_o   : second-stage (synchronized) value
module io_sync2
  import io_seq_pkg::*;
#(
  parameter int unsigned WIDTH = IO_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_seq_monitor.sv
// io_seq_monitor -- watches a pad bus for a fixed sequence of values.
// Each step must be seen for STABLE_CYCLES consecutive synchronized cycles;
// anything else on the bus is ignored. A global watchdog fails the run.
//   clk_i       : clock
//   rst_i       : asynchronous active-high reset
//   start_i     : one-cycle pulse, arms (or re-arms) a run
//   io_in_i     : monitored pad bus, asynchronous to clk_i
//   busy_o      : run in progress
//   pass_o      : sticky, full sequence seen
//   fail_o      : sticky, watchdog expired
//   step_idx_o  : index of the step being awaited (held after the run ends)
//   cycle_cnt_o : cycles spent in the current run (saturating)
module io_seq_monitor
  import io_seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS      = NUM_STEPS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [IO_W-1:0]   io_in_i,
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [STEP_W-1:0] step_idx_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  // stab counter only needs to hold 0..STABLE_CYCLES-1: the STABLE_CYCLES-th
  // match is the acceptance itself and clears it.
  localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST     = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP     = STEP_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [IO_W-1:0]   io_sync;
  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              match;
  logic              final_acc;

  io_sync2 #(.WIDTH(IO_W)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (io_in_i),
    .q_o   (io_sync)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    stab_d    = stab_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    match     = (io_sync == exp_value(step_q));
    final_acc = 1'b0;

    // start is honoured in every state, including mid-run.
    if (start_i) begin
      state_d = WAIT_STEP;
      step_d  = '0;
      cnt_d   = '0;
      stab_d  = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else if (state_q == WAIT_STEP) begin
      cnt_d = cnt_inc;
      if (!match) begin
        stab_d = '0;
      end else if (stab_q == STAB_LAST) begin
        stab_d = '0;
        // The final step keeps its index so it stays visible after PASS.
        if (step_q == LAST_STEP) final_acc = 1'b1;
        else                     step_d    = step_q + 1'b1;
      end else begin
        stab_d = stab_q + 1'b1;
      end

      // Completion takes priority over a coincident watchdog expiry.
      if (final_acc) begin
        state_d = PASS;
        pass_d  = 1'b1;
      end else if (cnt_inc == TIMEOUT_LIMIT) begin
        state_d = FAIL;
        fail_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      stab_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign busy_o      = (state_q == WAIT_STEP);
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign step_idx_o  = step_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_io_seq_monitor.sv
// tb_io_seq_monitor -- randomized and directed stimulus for io_seq_monitor,
// checked every cycle against a behavioural model of the sequence rules.
module tb_io_seq_monitor;

  localparam int unsigned T_STEPS = 12;
  localparam int unsigned T_TMO   = 120;
  localparam int unsigned T_STAB  = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  io_in_i;
  logic        busy_o;
  logic        pass_o;
  logic        fail_o;
  logic [3:0]  step_idx_o;
  logic [14:0] cycle_cnt_o;

  always #5 clk_i = ~clk_i;

  io_seq_monitor #(
    .NUM_STEPS      (T_STEPS),
    .TIMEOUT_CYCLES (T_TMO),
    .STABLE_CYCLES  (T_STAB)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .io_in_i     (io_in_i),
    .busy_o      (busy_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .step_idx_o  (step_idx_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  logic [7:0] exp_tab [0:11] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                 8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: run flag, sticky results, awaited step, elapsed cycles,
  // current run of consecutive matches, and the last two sampled pad values.
  bit         m_busy, m_pass, m_fail;
  int         m_step, m_cnt, m_run;
  logic [7:0] m_old1, m_old2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_pass = 0; m_fail = 0;
    m_step = 0; m_cnt = 0; m_run = 0;
    m_old1 = '0; m_old2 = '0;
  endtask

  task automatic model_edge();
    logic [7:0] seen;
    bit         last;
    seen = m_old2;  // pad value as it emerges from the synchronizer
    last = 0;
    if (start_i) begin
      m_busy = 1; m_pass = 0; m_fail = 0;
      m_step = 0; m_cnt = 0; m_run = 0;
    end else if (m_busy) begin
      if (m_cnt < 32767) m_cnt++;
      if (seen == exp_tab[m_step]) begin
        m_run++;
        if (m_run == T_STAB) begin
          m_run = 0;
          if (m_step == T_STEPS - 1) last = 1;
          else m_step++;
        end
      end else begin
        m_run = 0;
      end
      if (last) begin
        m_busy = 0; m_pass = 1;
      end else if (m_cnt == T_TMO - 1) begin
        m_busy = 0; m_fail = 1;
      end
    end
    m_old2 = m_old1;
    m_old1 = io_in_i;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
    check_eq("busy", busy_o, m_busy);
    check_eq("pass", pass_o, m_pass);
    check_eq("fail", fail_o, m_fail);
    check_eq("step_idx", step_idx_o, m_step);
    check_eq("cycle_cnt", cycle_cnt_o, m_cnt);
    check_eq("pass_fail_excl", pass_o & fail_o, 0);
  endtask

  task automatic drive(input logic [7:0] v, input int n);
    io_in_i = v;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic full_seq(input int hold);
    for (int s = 0; s < 12; s++) drive(exp_tab[s], hold);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (busy_o === 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check_eq({tag, "_done_in_budget"}, busy_o, 0);
  endtask

  task automatic expect_pass(input string tag);
    check_eq({tag, "_pass"}, pass_o, 1);
    check_eq({tag, "_fail"}, fail_o, 0);
    check_eq({tag, "_step"}, step_idx_o, 11);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_pass", pass_o, 0);
    check_eq("rst_fail", fail_o, 0);
    check_eq("rst_step", step_idx_o, 0);
    check_eq("rst_cnt", cycle_cnt_o, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] g;
    start_i = 1'b0;
    io_in_i = 8'h00;
    do_reset();
    drive(8'h01, 4);  // no arming without start

    // Nominal sequence, each value held 5 cycles
    pulse_start();
    full_seq(5);
    wait_done("nominal", 10);
    expect_pass("nominal");

    // Directed glitches and a too-short match
    pulse_start();
    drive(8'h01, 4); drive(8'h03, 1); drive(8'h01, 3); drive(8'h02, 4);
    drive(8'h03, 1); drive(8'h55, 3);
    check_eq("short_match_step", step_idx_o, 2);
    for (int s = 2; s < 12; s++) drive(exp_tab[s], 3);
    wait_done("glitch", 10);
    expect_pass("glitch");

    // Randomized holds with random 1-cycle glitches
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      for (int s = 0; s < 12; s++) begin
        if ($urandom_range(1, 0) == 1) begin
          g = 8'($urandom);
          if (g == exp_tab[s]) g = g ^ 8'h80;
          drive(g, 1);
        end
        drive(exp_tab[s], $urandom_range(4, 2));
      end
      wait_done("random", 10);
      expect_pass("random");
    end

    // Watchdog: stuck on 02
    pulse_start();
    drive(8'h01, 3);
    io_in_i = 8'h02;
    wait_done("timeout", T_TMO + 10);
    check_eq("tmo_fail", fail_o, 1);
    check_eq("tmo_pass", pass_o, 0);
    check_eq("tmo_cnt", cycle_cnt_o, T_TMO - 1);
    check_eq("tmo_step", step_idx_o, 2);
    drive(8'h02, 3);  // FAIL holds

    // Asynchronous reset mid-run at step 5
    pulse_start();
    for (int s = 0; s < 5; s++) drive(exp_tab[s], 3);
    drive(exp_tab[5], 1);
    check_eq("pre_rst_step", step_idx_o, 5);
    #2;
    do_reset();
    drive(8'h06, 3);
    pulse_start();
    full_seq(3);
    wait_done("post_reset", 10);
    expect_pass("post_reset");

    // Restart at step 7
    pulse_start();
    for (int s = 0; s < 7; s++) drive(exp_tab[s], 3);
    drive(exp_tab[7], 1);
    check_eq("pre_restart_step", step_idx_o, 7);
    pulse_start();
    check_eq("restart_step", step_idx_o, 0);
    check_eq("restart_cnt", cycle_cnt_o, 0);
    check_eq("restart_busy", busy_o, 1);
    full_seq(4);
    wait_done("restart", 10);
    expect_pass("restart");

    // Final acceptance lands on the timeout cycle
    drive(8'h55, 1);
    pulse_start();
    for (int j = 1; j <= int'(T_TMO) - 1; j++) begin
      if (j <= 33)       io_in_i = exp_tab[(j - 1) / 3];
      else if (j <= 115) io_in_i = 8'h55;
      else               io_in_i = 8'h00;
      tick();
    end
    check_eq("coinc_cnt", cycle_cnt_o, T_TMO - 1);
    check_eq("coinc_busy", busy_o, 0);
    expect_pass("coinc");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_seq_monitor.md
IO_SEQ_MONITOR -- requirements
Module: io_seq_monitor

Interface
REQ-001 Parameter NUM_STEPS, default 12: number of expected pattern steps.
REQ-002 Parameter TIMEOUT_CYCLES, default 25000: global watchdog limit in clock cycles.
REQ-003 Parameter STABLE_CYCLES, default 2: consecutive synchronized matches required per step.
REQ-004 clock  input  1: single clock for the block; the block has exactly one clock domain.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: single-cycle pulse that arms a run.
REQ-007 io_in  input  8: monitored pad bus (mprj_io[7:0]), asynchronous to clock.
REQ-008 busy  output  1: high while a run is armed.
REQ-009 pass  output  1: sticky; set when all steps have matched.
REQ-010 fail  output  1: sticky; set on watchdog timeout.
REQ-011 step_idx  output  4: index of the step currently awaited.
REQ-012 cycle_cnt  output  15: cycles elapsed in the current run.

Function
REQ-013 io_in passes through a 2-flop synchronizer; all compares use the second-flop value (io_sync).
REQ-014 FSM states: IDLE, WAIT_STEP, PASS, FAIL.
REQ-015 IDLE: on start, clear step_idx, cycle_cnt, pass, fail and the stability counter, then go to WAIT_STEP next cycle.
REQ-016 WAIT_STEP: stab_cnt increments each cycle io_sync == EXP[step_idx]; it clears on any mismatch.
REQ-017 Step acceptance: when stab_cnt reaches STABLE_CYCLES, advance step_idx by 1 and clear stab_cnt in the same cycle.
REQ-018 Non-matching intermediate values (glitches, stale values) are ignored; they are never a failure.
REQ-019 Accepting step NUM_STEPS-1 moves the FSM to PASS and sets pass on the following edge.
REQ-020 cycle_cnt increments every cycle in WAIT_STEP and saturates at its maximum value.
REQ-021 cycle_cnt reaching TIMEOUT_CYCLES-1 in WAIT_STEP moves the FSM to FAIL and sets fail.
REQ-022 If final-step acceptance and timeout occur in the same cycle, PASS wins.
REQ-023 PASS and FAIL hold until start (re-arm: same behaviour as from IDLE) or reset.
REQ-024 start asserted during WAIT_STEP restarts the run from step 0; the start pulse is not ignored.
REQ-025 busy = (state == WAIT_STEP); pass and fail are never high together.
REQ-026 step_idx holds its last value in PASS and FAIL, for diagnosis.

Reset
REQ-027 Reset asserted at any time, including mid-run, forces state IDLE, busy=0, pass=0, fail=0, step_idx=0, cycle_cnt=0, stab_cnt=0 and clears the synchronizer flops, asynchronously.
REQ-028 Reset deassertion does not arm the block; a start pulse is required.

Structure
REQ-029 Package io_seq_pkg holds the FSM state enum, the expected-value table EXP = {01,02,03,04,05,06,07,08,09,0A,FF,00}, and the default constants.
REQ-030 One sub-module, io_sync2 (8-bit two-flop synchronizer with async active-high reset), is instantiated; all other logic is flat.

Verification
REQ-031 Start, then drive 01..0A,FF,00, each held 5 cycles -> pass=1 about 2 cycles after the last value is accepted; fail=0; step_idx=11.
REQ-032 Start, then drive 01,02 and hold 02 -> fail=1 at cycle_cnt=24999; step_idx=2; busy=0.
REQ-033 Start, then drive 01, a 1-cycle 03 glitch, 01, 02... -> glitch ignored; step 2 is not advanced by a 1-cycle match; run still passes.
REQ-034 Apply reset mid-run at step 5 -> all outputs 0 immediately, without waiting for a clock edge; a new start passes a full sequence.
REQ-035 Arrange final acceptance to coincide with the timeout cycle (TIMEOUT_CYCLES overridden to a small value) -> pass=1, fail=0.
REQ-036 Pulse start at step 7 -> step_idx=0 and cycle_cnt=0 on the next cycle; the sequence restarts cleanly.
